// File: rtl/tlb_l2_arbiter_pkg.sv
// Shared MMU types for the L2 TLB request arbiter: requester ids and fence sequencing states.
package tlb_l2_arbiter_pkg;

  localparam int SV39_VPN_W = 27;

  typedef enum logic [1:0] {
    SRC_ITLB   = 2'd0,
    SRC_DLOAD  = 2'd1,
    SRC_DSTORE = 2'd2,
    SRC_AMO    = 2'd3
  } tlb_src_e;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_DONE  = 2'd2
  } tlb_arb_state_e;

endpackage

// File: rtl/tlb_l2_arbiter_rr_arbiter.sv
// Round-robin pick: the first valid requester at or after ptr wins, wrapping to index 0.
module tlb_l2_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [SRC_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   winner
);

  logic [NUM_REQ-1:0] upper;
  logic               found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
    assign upper[gi] = valid[gi] && (SRC_W'(gi) >= ptr);
  end

  // Requesters at or above ptr take priority; otherwise wrap to the lowest valid index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper[i]) begin
        found  = 1'b1;
        winner = SRC_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        found  = 1'b1;
        winner = SRC_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = enable && found && (winner == SRC_W'(gi));
  end

endmodule

// File: rtl/tlb_l2_arbiter.sv
// Arbitrates first-level TLB misses onto the single L2 TLB/PTW port, routes walk
// completions back by source id, and drains in-flight walks for sfence.vma.
module tlb_l2_arbiter
  import tlb_l2_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VPN_W   = SV39_VPN_W,
  parameter int IDX_W   = 6,
  parameter int MAX_OUT = 2,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VPN_W-1:0] req_vpn,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     l2_req,
  output logic [VPN_W-1:0]         l2_vpn,
  output logic [SRC_W-1:0]         l2_src,
  output logic [IDX_W-1:0]         l2_idx,
  input  logic                     l2_ready,
  input  logic                     l2_resp_valid,
  input  logic [SRC_W-1:0]         l2_resp_src,
  input  logic [IDX_W-1:0]         l2_resp_idx,
  input  logic                     l2_resp_exc,
  input  logic                     l2_resp_err,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [IDX_W-1:0]         resp_idx,
  output logic                     resp_exc,
  output logic                     resp_err,
  input  logic                     fence_req,
  output logic                     fence_busy,
  output logic                     fence_done,
  output logic                     proto_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = CNT_W + 1;

  tlb_arb_state_e     state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   winner;
  logic [CNT_W-1:0]   out_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] resp_hit;
  logic [VPN_W-1:0]   vpn_arr [NUM_REQ];
  logic [IDX_W-1:0]   idx_arr [NUM_REQ];
  logic               handshake;
  logic               credit_ok;
  logic               can_issue;
  logic               granted;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign vpn_arr[gi]  = req_vpn[gi*VPN_W +: VPN_W];
    assign idx_arr[gi]  = req_idx[gi*IDX_W +: IDX_W];
    assign resp_hit[gi] = l2_resp_valid && (l2_resp_src == SRC_W'(gi));
  end

  assign handshake = l2_req && l2_ready;
  // The pending output entry already holds a credit; freed credits apply next cycle.
  assign credit_ok = (SUM_W'(out_cnt) + SUM_W'(l2_req)) < SUM_W'(MAX_OUT);
  // fence_req blocks the grant in the same cycle because the next state is DRAIN.
  assign can_issue = (state == ARB_RUN) && !fence_req && credit_ok && (!l2_req || l2_ready);
  assign granted   = |grant;
  assign req_ready = grant;
  assign fence_busy = (state != ARB_RUN);

  tlb_l2_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .enable(can_issue),
    .grant (grant),
    .winner(winner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_RUN;
      rr_ptr     <= '0;
      out_cnt    <= '0;
      l2_req     <= 1'b0;
      l2_vpn     <= '0;
      l2_src     <= '0;
      l2_idx     <= '0;
      resp_valid <= '0;
      resp_idx   <= '0;
      resp_exc   <= 1'b0;
      resp_err   <= 1'b0;
      fence_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (granted) begin
        l2_req <= 1'b1;
        l2_vpn <= vpn_arr[winner];
        l2_src <= winner;
        l2_idx <= idx_arr[winner];
        rr_ptr <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (handshake) begin
        l2_req <= 1'b0;
      end

      // A completion with nothing outstanding is flagged but not counted.
      if (l2_resp_valid && (out_cnt == '0)) begin
        proto_err <= 1'b1;
        if (handshake) out_cnt <= out_cnt + 1'b1;
      end else if (handshake && !l2_resp_valid) begin
        out_cnt <= out_cnt + 1'b1;
      end else if (!handshake && l2_resp_valid) begin
        out_cnt <= out_cnt - 1'b1;
      end

      resp_valid <= resp_hit;
      resp_idx   <= l2_resp_idx;
      resp_exc   <= l2_resp_exc;
      resp_err   <= l2_resp_err;

      case (state)
        ARB_RUN: begin
          fence_done <= 1'b0;
          if (fence_req) state <= ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if ((out_cnt == '0) && !l2_req) begin
            state      <= ARB_DONE;
            fence_done <= 1'b1;
          end
        end
        ARB_DONE: begin
          state      <= ARB_RUN;
          fence_done <= 1'b0;
        end
        default: begin
          state      <= ARB_RUN;
          fence_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_l2_arbiter.sv
// Randomized and directed bench for tlb_l2_arbiter against a behavioural model of its rules.
module tb_tlb_l2_arbiter;

  localparam int N  = 4;
  localparam int VW = 27;
  localparam int IW = 6;
  localparam int MO = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*VW-1:0] req_vpn = '0;
  logic [N*IW-1:0] req_idx = '0;
  logic [N-1:0]    req_ready;
  logic            l2_req;
  logic [VW-1:0]   l2_vpn;
  logic [SW-1:0]   l2_src;
  logic [IW-1:0]   l2_idx;
  logic            l2_ready = 1'b0;
  logic            l2_resp_valid = 1'b0;
  logic [SW-1:0]   l2_resp_src = '0;
  logic [IW-1:0]   l2_resp_idx = '0;
  logic            l2_resp_exc = 1'b0;
  logic            l2_resp_err = 1'b0;
  logic [N-1:0]    resp_valid;
  logic [IW-1:0]   resp_idx;
  logic            resp_exc;
  logic            resp_err;
  logic            fence_req = 1'b0;
  logic            fence_busy;
  logic            fence_done;
  logic            proto_err;

  tlb_l2_arbiter #(
    .NUM_REQ(N), .VPN_W(VW), .IDX_W(IW), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vpn(req_vpn), .req_idx(req_idx), .req_ready(req_ready),
    .l2_req(l2_req), .l2_vpn(l2_vpn), .l2_src(l2_src), .l2_idx(l2_idx), .l2_ready(l2_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_src(l2_resp_src), .l2_resp_idx(l2_resp_idx),
    .l2_resp_exc(l2_resp_exc), .l2_resp_err(l2_resp_err),
    .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_exc(resp_exc), .resp_err(resp_err),
    .fence_req(fence_req), .fence_busy(fence_busy), .fence_done(fence_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=RUN 1=DRAIN 2=DONE; walks in flight kept as a plain integer.
  bit            model_valid = 1'b0;
  bit            have_next   = 1'b0;
  int            m_state, m_ptr, m_out;
  bit            m_l2_req, m_proto, m_rexc, m_rerr;
  logic [VW-1:0] m_vpn;
  logic [SW-1:0] m_src;
  logic [IW-1:0] m_idx, m_ridx;
  logic [N-1:0]  m_rv;
  int            n_state, n_ptr, n_out;
  bit            n_l2_req, n_proto, n_rexc, n_rerr;
  logic [VW-1:0] n_vpn;
  logic [SW-1:0] n_src;
  logic [IW-1:0] n_idx, n_ridx;
  logic [N-1:0]  n_rv;

  initial begin : compare
    int           win;
    bit           can, hs;
    logic [N-1:0] exp_ready;
    forever begin
      @(posedge clk);
      if (have_next) begin
        m_state = n_state; m_ptr = n_ptr; m_out = n_out; m_l2_req = n_l2_req;
        m_proto = n_proto; m_rexc = n_rexc; m_rerr = n_rerr; m_vpn = n_vpn;
        m_src = n_src; m_idx = n_idx; m_ridx = n_ridx; m_rv = n_rv;
        model_valid = 1'b1;
      end
      @(negedge clk);
      win = -1;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_ptr + k) % N;
        if (win < 0 && req_valid[r]) win = r;
      end
      can = (m_state == 0) && !fence_req && (m_out + int'(m_l2_req) < MO) && (!m_l2_req || l2_ready);
      exp_ready = (can && win >= 0) ? N'(1 << win) : '0;
      if (model_valid) begin
        chk("req_ready", req_ready, exp_ready);
        chk("l2_req", l2_req, m_l2_req);
        chk("l2_vpn", l2_vpn, m_vpn);
        chk("l2_src", l2_src, m_src);
        chk("l2_idx", l2_idx, m_idx);
        chk("resp_valid", resp_valid, m_rv);
        chk("resp_idx", resp_idx, m_ridx);
        chk("resp_exc", resp_exc, m_rexc);
        chk("resp_err", resp_err, m_rerr);
        chk("fence_busy", fence_busy, m_state != 0);
        chk("fence_done", fence_done, m_state == 2);
        chk("proto_err", proto_err, m_proto);
      end
      if (!rst) begin
        n_state = 0; n_ptr = 0; n_out = 0; n_l2_req = 0; n_proto = 0; n_rexc = 0;
        n_rerr = 0; n_vpn = '0; n_src = '0; n_idx = '0; n_ridx = '0; n_rv = '0;
      end else begin
        hs = m_l2_req && l2_ready;
        n_state = m_state; n_ptr = m_ptr; n_l2_req = m_l2_req; n_proto = m_proto;
        n_vpn = m_vpn; n_src = m_src; n_idx = m_idx;
        if (exp_ready != '0) begin
          n_l2_req = 1'b1;
          n_vpn = req_vpn[win*VW +: VW];
          n_idx = req_idx[win*IW +: IW];
          n_src = SW'(win);
          n_ptr = (win + 1) % N;
        end else if (hs) begin
          n_l2_req = 1'b0;
        end
        if (l2_resp_valid && m_out == 0) begin
          n_proto = 1'b1;
          n_out = m_out + int'(hs);
        end else begin
          n_out = m_out + int'(hs) - int'(l2_resp_valid);
        end
        n_rv   = (l2_resp_valid && int'(l2_resp_src) < N) ? N'(1 << l2_resp_src) : '0;
        n_ridx = l2_resp_idx;
        n_rexc = l2_resp_exc;
        n_rerr = l2_resp_err;
        case (m_state)
          0:       n_state = fence_req ? 1 : 0;
          1:       n_state = (m_out == 0 && !m_l2_req) ? 2 : 1;
          default: n_state = 0;
        endcase
      end
      have_next = 1'b1;
    end
  end

  logic [SW-1:0] hs_q[$];

  task automatic to_neg();
    @(negedge clk);
    if (l2_req && l2_ready) begin
      hs_q.push_back(l2_src);
      $display("walk src=%0d vpn=0x%0h idx=0x%0h", l2_src, l2_vpn, l2_idx);
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_vpn = '0; req_idx = '0; l2_ready = 1'b0; fence_req = 1'b0;
    l2_resp_valid = 1'b0; l2_resp_src = '0; l2_resp_idx = '0; l2_resp_exc = 1'b0; l2_resp_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    hs_q.delete();
  endtask

  initial begin : driver
    // Round robin order and credit limit, starting from reset.
    do_reset();
    req_valid = 4'hF;
    l2_ready  = 1'b1;
    for (int i = 0; i < N; i++) req_vpn[i*VW +: VW] = VW'(32'h100 + i);
    to_neg();
    chk("reset_l2_req", l2_req, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_proto_err", proto_err, 0);
    chk("reset_fence_done", fence_done, 0);
    chk("reset_l2_vpn", l2_vpn, 0);
    chk("rr_grant0", req_ready, 4'b0001);
    to_next();
    to_neg();
    chk("rr_grant1", req_ready, 4'b0010);
    chk("rr_src0", l2_src, 0);
    to_next();
    to_neg();
    chk("credit_block", req_ready, 4'b0000);
    chk("rr_vpn1", l2_vpn, 27'h101);
    to_next();
    l2_resp_valid = 1'b1; l2_resp_src = 2'd2; l2_resp_idx = 6'h2A;
    to_neg();
    chk("credit_full", req_ready, 4'b0000);
    to_next();
    l2_resp_valid = 1'b0;
    to_neg();
    chk("resp_onehot", resp_valid, 4'b0100);
    chk("resp_idx_lit", resp_idx, 6'h2A);
    chk("regrant", req_ready, 4'b0100);
    to_next();

    // L2 back-pressure holds the output register.
    do_reset();
    req_valid = 4'b0001;
    req_vpn[0 +: VW] = 27'h1ABCD;
    to_neg();
    chk("stall_grant", req_ready, 4'b0001);
    to_next();
    req_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      to_neg();
      chk("stall_ready", req_ready, 4'b0000);
      chk("stall_req", l2_req, 1);
      chk("stall_vpn", l2_vpn, 27'h1ABCD);
      to_next();
    end
    l2_ready = 1'b1;
    to_neg();
    chk("stall_release", req_ready, 4'b0010);
    to_next();

    // Fence with one walk outstanding.
    do_reset();
    req_valid = 4'b0001; l2_ready = 1'b1;
    to_neg(); to_next();
    req_valid = 4'b0000;
    to_neg(); to_next();
    fence_req = 1'b1; req_valid = 4'hF;
    to_neg();
    chk("fence_same_cycle", req_ready, 4'b0000);
    to_next();
    fence_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk("drain_busy", fence_busy, 1);
      chk("drain_ready", req_ready, 4'b0000);
      to_next();
    end
    l2_resp_valid = 1'b1; l2_resp_src = 2'd0;
    to_neg(); to_next();
    l2_resp_valid = 1'b0;
    to_neg();
    chk("drain_resp", resp_valid, 4'b0001);
    chk("drain_not_done", fence_done, 0);
    to_next();
    to_neg();
    chk("fence_done_pulse", fence_done, 1);
    chk("done_ready", req_ready, 4'b0000);
    to_next();
    to_neg();
    chk("fence_done_clear", fence_done, 0);
    chk("fence_idle", fence_busy, 0);
    chk("resume_grant", req_ready, 4'b0010);
    to_next();

    // Response with nothing outstanding, then reset in the middle of a drain.
    do_reset();
    l2_resp_valid = 1'b1; l2_resp_src = 2'd1; l2_resp_idx = 6'h05;
    to_neg();
    chk("proto_before", proto_err, 0);
    to_next();
    l2_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk("proto_sticky", proto_err, 1);
      if (c == 0) chk("proto_routed", resp_valid, 4'b0010);
      to_next();
    end
    req_valid = 4'b0001; l2_ready = 1'b1;
    to_neg(); to_next();
    req_valid = 4'b0000;
    to_neg(); to_next();
    fence_req = 1'b1;
    to_neg(); to_next();
    fence_req = 1'b0;
    to_neg();
    chk("mid_drain_busy", fence_busy, 1);
    to_next();
    rst = 1'b0;
    to_neg(); to_next();
    rst = 1'b1;
    hs_q.delete();
    to_neg();
    chk("rst_fence_busy", fence_busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_l2_req", l2_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fence_done", fence_done, 0);
    to_next();

    // Random traffic; L2 answers only walks it has accepted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_vpn[i*VW +: VW] = VW'($urandom);
        req_idx[i*IW +: IW] = IW'($urandom);
      end
      l2_ready  = ($urandom_range(0, 3) != 0);
      fence_req = ($urandom_range(0, 59) == 0);
      if (hs_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        l2_resp_valid = 1'b1;
        l2_resp_src   = hs_q.pop_front();
      end else begin
        l2_resp_valid = 1'b0;
        l2_resp_src   = SW'($urandom);
      end
      l2_resp_idx = IW'($urandom);
      l2_resp_exc = 1'($urandom);
      l2_resp_err = 1'($urandom);
      to_neg();
      to_next();
    end
    idle_inputs();
    to_neg();
    chk("random_no_proto", proto_err, 0);
    to_next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
